lincomb_solver: RTL and testbench



---
 rtl/lincomb_solver.sv | 118 +++++++++++
 tb/tb_lincomb_solver.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/lincomb_solver.sv
// Recovers (a, b) from c = KA*a + KB*b by scanning one candidate a per cycle.
// Define SOLVER_EARLY_EXIT_EN to stop at the first hit (multi then stays 0).
module lincomb_solver #(
    parameter int unsigned A_W = 4,
    parameter int unsigned B_W = 4,
    parameter int unsigned C_W = 9,
    parameter int unsigned KA  = 12,
    parameter int unsigned KB  = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [C_W-1:0] c,
    output logic           out_valid,
    output logic [A_W-1:0] a,
    output logic [B_W-1:0] b,
    output logic           found,
    output logic           multi
);
    localparam int unsigned R_W = C_W + 1;
    localparam logic [A_W-1:0]        IDX_LAST = '1;
    localparam logic [C_W-1:0]        KB_C     = C_W'(KB);
    localparam logic [C_W-1:0]        B_MAX    = C_W'((2 ** B_W) - 1);
    localparam logic signed [R_W-1:0] KA_R     = R_W'(KA);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_e;

    state_e                state_q, state_d;
    logic signed [R_W-1:0] r_q, r_d;
    logic [A_W-1:0]        idx_q, idx_d;
    logic [A_W-1:0]        a_q, a_d;
    logic [B_W-1:0]        b_q, b_d;
    logic                  found_q, found_d;
    logic                  multi_q, multi_d;

    logic [C_W-1:0] r_mag, quo, rem;
    logic           hit;

    always_comb begin
        r_mag = r_q[C_W-1:0];
        quo   = r_mag / KB_C;
        rem   = r_mag % KB_C;
        hit   = !r_q[R_W-1] && (rem == '0) && (quo <= B_MAX);
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        found_d = found_q;
        multi_d = multi_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    r_d     = {1'b0, c};
                    idx_d   = '0;
                    a_d     = '0;
                    b_d     = '0;
                    found_d = 1'b0;
                    multi_d = 1'b0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                // Residue stops moving once negative: no later candidate can hit.
                if (!r_q[R_W-1]) r_d = r_q - KA_R;
                if (idx_q == IDX_LAST) state_d = DONE;
                else                   idx_d   = idx_q + 1'b1;
                if (hit) begin
                    if (!found_q) begin
                        a_d     = idx_q;
                        b_d     = quo[B_W-1:0];
                        found_d = 1'b1;
`ifdef SOLVER_EARLY_EXIT_EN
                        state_d = DONE;
`endif
                    end else begin
`ifndef SOLVER_EARLY_EXIT_EN
                        multi_d = 1'b1;
`endif
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            found_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            found_q <= found_d;
            multi_q <= multi_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign a         = a_q;
    assign b         = b_q;
    assign found     = found_q;
    assign multi     = multi_q;
endmodule

// File: tb/tb_lincomb_solver.sv
// Directed-vector bench for lincomb_solver (default 12a + 5b, 4-bit operands).
module tb_lincomb_solver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] c = '0;
    logic       out_valid;
    logic [3:0] a, b;
    logic       found, multi;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    lincomb_solver #(.A_W(4), .B_W(4), .C_W(9), .KA(12), .KB(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .c(c),
        .out_valid(out_valid), .a(a), .b(b), .found(found), .multi(multi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int unsigned n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Waits for out_valid; returns the number of cycles after the acceptance edge.
    task automatic wait_done(output int unsigned cnt);
        cnt = 0;
        forever begin
            @(negedge clk);
            if (out_valid || cnt >= 40) break;
            cnt++;
        end
        if (!out_valid) check("done_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic run_code(input logic [8:0] cv, input logic [3:0] ea, input logic [3:0] eb,
                            input logic ef, input logic em);
        int unsigned cnt, lat;
        logic        em_x;
        lat  = 16;
        em_x = em;
`ifdef SOLVER_EARLY_EXIT_EN
        if (ef) lat = 32'(ea) + 1;
        em_x = 1'b0;
`endif
        wait_ready();
        in_valid = 1'b1;
        c        = cv;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (out_valid) cnt = 1;
        else begin
            wait_done(cnt);
            cnt++;
        end
        check($sformatf("lat_c%0d", cv), cnt, lat);
        check($sformatf("a_c%0d", cv), 32'(a), 32'(ea));
        check($sformatf("b_c%0d", cv), 32'(b), 32'(eb));
        check($sformatf("found_c%0d", cv), 32'(found), 32'(ef));
        check($sformatf("multi_c%0d", cv), 32'(multi), 32'(em_x));
        check($sformatf("busy_ready_c%0d", cv), 32'(in_ready), 32'd0);
        @(negedge clk);
        check($sformatf("pulse_end_c%0d", cv), 32'(out_valid), 32'd0);
        check($sformatf("ready_back_c%0d", cv), 32'(in_ready), 32'd1);
        check($sformatf("hold_a_c%0d", cv), 32'(a), 32'(ea));
    endtask

    initial begin : main
        int unsigned cnt, pulses;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_oval", 32'(out_valid), 32'd0);
        check("rst_outs", {a, b, found, multi}, 32'd0);
        rst = 1'b0;

        run_code(9'd0,   4'd0,  4'd0,  1'b1, 1'b0);
        run_code(9'd17,  4'd1,  4'd1,  1'b1, 1'b0);
        run_code(9'd255, 4'd15, 4'd15, 1'b1, 1'b0);
        run_code(9'd60,  4'd0,  4'd12, 1'b1, 1'b1);
        run_code(9'd1,   4'd0,  4'd0,  1'b0, 1'b0);
        run_code(9'd300, 4'd0,  4'd0,  1'b0, 1'b0);
        run_code(9'd29,  4'd2,  4'd1,  1'b1, 1'b0);
        run_code(9'd137, 4'd6,  4'd13, 1'b1, 1'b1);
        run_code(9'd511, 4'd0,  4'd0,  1'b0, 1'b0);

        // Back-to-back with in_valid held high throughout.
        wait_ready();
        in_valid = 1'b1;
        c        = 9'd17;
        @(posedge clk);
        wait_done(cnt);
        check("b2b_first_a", 32'(a), 32'd1);
        check("b2b_first_b", 32'(b), 32'd1);
        c = 9'd60;
        @(negedge clk);
        check("b2b_idle_ready", 32'(in_ready), 32'd1);
        check("b2b_idle_oval", 32'(out_valid), 32'd0);
        @(posedge clk);
        wait_done(cnt);
        check("b2b_second_a", 32'(a), 32'd0);
        check("b2b_second_b", 32'(b), 32'd12);
        in_valid = 1'b0;
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("b2b_no_extra_pulse", pulses, 32'd0);

        // Reset in the middle of a search.
        wait_ready();
        in_valid = 1'b1;
        c        = 9'd60;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_outs", {a, b, found, multi}, 32'd0);
        check("arst_oval", 32'(out_valid), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("arst_no_pulse", pulses, 32'd0);
        run_code(9'd5, 4'd0, 4'd1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
